// File: rtl/alu_pkg.sv
// Shared types and opcodes for the ALU issue stage and its command FIFO.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // One queued ALU command; when use_acc is set, a is ignored at issue.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        sel;
        logic              use_acc;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of alu_cmd_t. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output alu_cmd_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    alu_cmd_t    mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; guarded so an overflowing push or underflowing pop is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because head is only used when not empty.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational 8-bit ALU: queues commands, drives
// the ALU from the queue head, and captures result/carry/zero in an output slot.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// producer holds valid and its data stable until the transfer; valid never
// depends on ready. in_ready is !full only (no same-cycle pop pass-through);
// out_* are held stable while out_valid && !out_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_sel,
    input  logic              in_use_acc,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_zero,
    output logic [DATA_W-1:0] acc_value
);

    alu_cmd_t in_cmd;
    alu_cmd_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     head_valid;
    logic     push;
    logic     issue;

    assign in_cmd.a       = in_a;
    assign in_cmd.b       = in_b;
    assign in_cmd.sel     = in_sel;
    assign in_cmd.use_acc = in_use_acc;

    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign head_valid = !fifo_empty;
    assign issue      = head_valid && (!out_valid || out_ready);

    alu_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(in_cmd),
        .pop      (issue),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    // ALU operands from the head; A resolves against the accumulator at issue time.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = OP_AND;
        if (head_valid) begin
            alu_a   = head.use_acc ? acc_value : head.a;
            alu_b   = head.b;
            alu_sel = head.sel;
        end
    end

    // Output slot: load on issue, drop valid on a drain with nothing to issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_carry  <= alu_carry;
            out_zero   <= (alu_result == '0);
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Accumulator: clear wins over the issue update in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_value <= '0;
        end else if (acc_clr) begin
            acc_value <= '0;
        end else if (issue) begin
            acc_value <= alu_result;
        end
    end

endmodule
